// File: rtl/agg_accumulator_if.sv
// Stream interface for agg_accumulator: a sample input channel and a group result channel.
// Both channels use valid/ready: a transfer occurs on a rising clk edge where valid and ready are both 1;
// valid must not wait on ready, and the source holds its payload stable while valid=1 and ready=0.
interface agg_accumulator_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;
  logic                    out_forced;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf, out_forced
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf, out_forced
  );
endinterface

// File: rtl/agg_accumulator.sv
// Streaming group accumulator: sums signed samples per group and holds {sum, count, flags} until taken.
// Optional macro AGG_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module agg_accumulator #(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 20,
  parameter int CNT_W     = 8,
  parameter int MAX_ELEMS = 255
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               clear,
  agg_accumulator_if.slave   bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ELEMS);
`ifdef AGG_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;
  logic                    forced;
  logic                    out_valid_q;

  logic                    beat;
  logic                    closing;
  logic                    forced_now;
  logic                    ovf_now;
  logic signed [ACC_W:0]   base_w;
  logic signed [ACC_W:0]   sample_w;
  logic signed [ACC_W:0]   sum_w;
  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        cnt_base;
  logic [CNT_W-1:0]        cnt_next;

  // No bypass from HOLD: a new group is accepted only after the held result has left.
  assign bus.in_ready = arst_n & (state != HOLD);
  assign beat         = bus.in_valid & bus.in_ready;

  always_comb begin
    base_w     = (state == IDLE) ? '0 : {acc[ACC_W-1], acc};
    sample_w   = {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    sum_w      = base_w + sample_w;
    // One guard bit is enough: a single add of ACC_W-bit operands cannot escape ACC_W+1 bits.
    ovf_now    = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    acc_next   = sum_w[ACC_W-1:0];
`ifdef AGG_SATURATE_EN
    if (ovf_now) begin
      acc_next = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
`endif
    cnt_base   = (state == IDLE) ? '0 : cnt;
    cnt_next   = cnt_base + CNT_W'(1);
    forced_now = ~bus.in_last & (cnt_next == MAX_CNT);
    closing    = bus.in_last | (cnt_next == MAX_CNT);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      forced      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      forced      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat) begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ((state == ACCUM) & ovf) | ovf_now;
            if (closing) begin
              state       <= HOLD;
              forced      <= forced_now;
              out_valid_q <= 1'b1;
            end else begin
              state  <= ACCUM;
              forced <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sum    = acc;
  assign bus.out_count  = cnt;
  assign bus.out_ovf    = ovf;
  assign bus.out_forced = forced;
  assign dbg_state      = state;

endmodule

// File: tb/tb_agg_accumulator.sv
// Self-checking bench for agg_accumulator: vector table, corner-case sequences, randomized scoreboard.
// Build with +define+AGG_SATURATE_EN to check the clamping variant.
module tb_agg_accumulator;

  localparam int IN_W   = 16;
  localparam int ACC_W  = 20;
  localparam int CNT_W  = 8;
  localparam int TB_MAX = 20;
  localparam int SUM_MAX = (1 << (ACC_W-1)) - 1;
  localparam int SUM_MIN = -(1 << (ACC_W-1));

  logic       clk;
  logic       arst_n;
  logic       clear;
  logic [1:0] dbg_state;

  agg_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  agg_accumulator #(
    .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .MAX_ELEMS(TB_MAX)
  ) dut (
    .clk(clk), .arst_n(arst_n), .clear(clear), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input int sum, input int cnt,
                              input int ovf, input int frc);
    check({tag, "_valid"},  int'(bus.out_valid), 1);
    check({tag, "_sum"},    int'($signed(bus.out_sum)), sum);
    check({tag, "_count"},  int'(bus.out_count), cnt);
    check({tag, "_ovf"},    int'(bus.out_ovf), ovf);
    check({tag, "_forced"}, int'(bus.out_forced), frc);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge right after the sample was accepted.
  task automatic send(input int d, input bit last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(d);
    bus.in_last  = last;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send_timeout", guard, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n;
    int d[4];
    int sum;
  } vec_t;

  vec_t vecs[6];

  task automatic add_vec(input int i, input int n, input int a, input int b,
                         input int c, input int e, input int sum);
    vecs[i].n    = n;
    vecs[i].d[0] = a;
    vecs[i].d[1] = b;
    vecs[i].d[2] = c;
    vecs[i].d[3] = e;
    vecs[i].sum  = sum;
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [ACC_W+CNT_W+1:0] exp_q[$];
  int m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  function automatic logic [ACC_W+CNT_W+1:0] pack(input int sum, input int cnt,
                                                  input bit ovf, input bit frc);
    logic [31:0] s;
    logic [31:0] c;
    s = sum;
    c = cnt;
    return {s[ACC_W-1:0], c[CNT_W-1:0], ovf, frc};
  endfunction

  task automatic model_beat(input int d, input bit last);
    int t;
    t = m_acc + d;
    if (t > SUM_MAX || t < SUM_MIN) begin
      m_ovf = 1'b1;
`ifdef AGG_SATURATE_EN
      t = (t > 0) ? SUM_MAX : SUM_MIN;
`else
      t = (t > 0) ? t - (1 << ACC_W) : t + (1 << ACC_W);
`endif
    end
    m_acc = t;
    m_cnt++;
    if (last || m_cnt == TB_MAX) begin
      exp_q.push_back(pack(m_acc, m_cnt, m_ovf, !last && m_cnt == TB_MAX));
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end
  endtask

  typedef struct {
    int d;
    bit last;
  } samp_t;

  samp_t stim_q[$];

  // ---------------- test sequence ----------------
  initial begin
    int exp_ovf_sum;
    arst_n        = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    add_vec(0, 3, 3, -5, 10, 0, 8);
    add_vec(1, 1, 7, 0, 0, 0, 7);
    add_vec(2, 4, -32768, -32768, -32768, -32768, -131072);
    add_vec(3, 4, 32767, 1, -2, 0, 32766);
    add_vec(4, 2, -1, 1, 0, 0, 0);
    add_vec(5, 2, 100, -300, 0, 0, -200);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_valid",    int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_sum",      int'($signed(bus.out_sum)), 0);
    check("rst_count",    int'(bus.out_count), 0);
    check("rst_flags",    int'({bus.out_ovf, bus.out_forced}), 0);
    check("rst_state",    int'(dbg_state), 0);
    arst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(bus.in_ready), 1);

    // Table: back-to-back groups with out_ready held high
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n; k++) send(vecs[i].d[k], k == vecs[i].n - 1);
      check_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].n, 0, 0);
      @(negedge clk);
      check($sformatf("vec%0d_done", i), int'(bus.out_valid), 0);
      check($sformatf("vec%0d_ready", i), int'(bus.in_ready), 1);
    end

    // Backpressure: result held for 4 cycles
    bus.out_ready = 1'b0;
    send(7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_result("hold", 7, 1, 0, 0);
      check("hold_in_ready", int'(bus.in_ready), 0);
      if (i < 3) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", int'(bus.out_valid), 0);
    check("hold_release_ready", int'(bus.in_ready), 1);

    // Forced close at TB_MAX, next sample stalls until the result leaves
    bus.out_ready = 1'b0;
    for (int k = 0; k < TB_MAX; k++) send(1, 1'b0);
    check_result("forced", TB_MAX, TB_MAX, 0, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(1);
    bus.in_last  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("forced_stall_ready", int'(bus.in_ready), 0);
    check("forced_stall_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("forced_exit_valid", int'(bus.out_valid), 0);
    check("forced_exit_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_result("forced_next", 1, 1, 0, 0);
    @(negedge clk);

    // Overflow: 17 x 32767 exceeds the 20-bit signed range on the last beat
`ifdef AGG_SATURATE_EN
    exp_ovf_sum = SUM_MAX;
`else
    exp_ovf_sum = 17 * 32767 - (1 << ACC_W);
`endif
    for (int k = 0; k < 17; k++) send(32767, k == 16);
    check_result("ovf", exp_ovf_sum, 17, 1, 0);
    @(negedge clk);
    send(-4, 1'b1);
    check_result("ovf_cleared", -4, 1, 0, 0);
    @(negedge clk);

    // Clear mid-group drops the partial sum and a same-cycle beat
    send(5, 1'b0);
    send(6, 1'b0);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(100);
    bus.in_last  = 1'b1;
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_valid", int'(bus.out_valid), 0);
    check("clr_sum",   int'($signed(bus.out_sum)), 0);
    check("clr_count", int'(bus.out_count), 0);
    check("clr_state", int'(dbg_state), 0);
    send(2, 1'b1);
    check_result("clr_next", 2, 1, 0, 0);
    @(negedge clk);

    // Clear during HOLD discards the held result
    bus.out_ready = 1'b0;
    send(9, 1'b1);
    check("clr_hold_before", int'(bus.out_valid), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_hold_valid", int'(bus.out_valid), 0);
    check("clr_hold_ready", int'(bus.in_ready), 1);
    check("clr_hold_sum",   int'($signed(bus.out_sum)), 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("clr_hold_none", int'(bus.out_valid), 0);

    // Asynchronous reset mid-group
    send(4, 1'b0);
    send(4, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    check("arst_sum",      int'($signed(bus.out_sum)), 0);
    check("arst_count",    int'(bus.out_count), 0);
    check("arst_in_ready", int'(bus.in_ready), 0);
    check("arst_state",    int'(dbg_state), 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    send(5, 1'b1);
    check_result("arst_next", 5, 1, 0, 0);
    @(negedge clk);

    // Randomized stream against the reference model
    for (int g = 0; g < 40; g++) begin
      int len;
      len = $urandom_range(1, 25);
      for (int k = 0; k < len; k++) begin
        samp_t s;
        logic signed [IN_W-1:0] raw;
        raw = IN_W'($urandom);
        s.d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2000)) - 1000 : int'(raw);
        s.last = (k == len - 1);
        stim_q.push_back(s);
      end
    end
    begin
      int idx;
      int cyc;
      bit rdy_seen;
      idx = 0;
      cyc = 0;
      rdy_seen = 1'b0;
      bus.out_ready = 1'b0;
      while ((idx < stim_q.size() || exp_q.size() != 0) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (bus.in_valid && rdy_seen) begin
          model_beat(stim_q[idx].d, stim_q[idx].last);
          idx++;
        end
        bus.in_valid = 1'b0;
        if (bus.out_valid) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          if (bus.out_ready) begin
            check("rand_pending", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
              check("rand_result",
                    int'({bus.out_sum, bus.out_count, bus.out_ovf, bus.out_forced}),
                    int'(exp_q.pop_front()));
          end
        end else begin
          bus.out_ready = ($urandom_range(0, 1) == 1);
        end
        if (idx < stim_q.size() && $urandom_range(0, 3) != 0) begin
          bus.in_valid = 1'b1;
          bus.in_data  = IN_W'(stim_q[idx].d);
          bus.in_last  = stim_q[idx].last;
        end
        rdy_seen = bus.in_ready;
      end
      check("rand_leftover", (stim_q.size() - idx) + exp_q.size(), 0);
      @(negedge clk);
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("rand_drained", int'(bus.out_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
